procesador_calc_sequencer: RTL
==============================

// Module: procesador_calc_sequencer
// PURPOSE
//  Sequences the signal-processing engine for the Nios CPU: on a CPU start command, issues
//  N_FRAMES start pulses to the engine, counts its done pulses, enforces a per-frame timeout
//  and drives the sticky calc_finalizado level/IRQ. Avalon-MM slave on the CPU bus;
//  calc_finalizado feeds the existing 1-bit input PIO.
// PARAMETERS
//  FRAME_W      16      width of frame count register / counter
//  TIMEOUT_W    24      width of per-frame watchdog counter
//  TIMEOUT_DEF  24'hFFFFFF  reset value of TIMEOUT register (cycles)
// PORTS
//  clk             in   1   system clock (only clock)
//  reset           in   1   synchronous, active-high reset
//  address         in   2   Avalon-MM register select
//  read            in   1   Avalon read strobe
//  write           in   1   Avalon write strobe
//  writedata       in   32  Avalon write data
//  readdata        out  32  Avalon read data, registered, 1-cycle latency
//  eng_start       out  1   one-cycle pulse: engine begins one frame
//  eng_clear       out  1   one-cycle pulse: engine flushes accumulators (run start/abort)
//  eng_done        in   1   one-cycle pulse: engine finished current frame
//  calc_finalizado out  1   sticky run-complete flag (to PIO in_port)
//  irq             out  1   calc_finalizado & IRQ_EN
// BEHAVIOUR
//  Registers: 0 CTRL (W: b0 START, b1 ABORT, b2 IRQ_EN; R: b2 IRQ_EN); 1 STATUS (R: b0 DONE,
//   b1 BUSY, b2 TIMEOUT_ERR, b[31:16] frames_done; W: b0=1 clears DONE and TIMEOUT_ERR);
//   2 N_FRAMES (RW, FRAME_W bits, zero-extended); 3 TIMEOUT (RW, TIMEOUT_W bits).
//  readdata <= mux(address) on every clk; unmapped bits read 0. Reads have no side effects.
//  Reset: state=IDLE, readdata=0, eng_start=0, eng_clear=0, calc_finalizado=0, irq=0,
//   IRQ_EN=0, N_FRAMES=1, TIMEOUT=TIMEOUT_DEF, frames_done=0, TIMEOUT_ERR=0.
//  FSM states: IDLE, CLEAR, ISSUE, WAIT, FINISH.
//   IDLE:   START write with N_FRAMES!=0 -> CLEAR; clears DONE, TIMEOUT_ERR, frames_done.
//           START with N_FRAMES==0 -> stays IDLE, sets DONE immediately (no engine activity).
//   CLEAR:  eng_clear=1 for this cycle -> ISSUE.
//   ISSUE:  eng_start=1 for this cycle, watchdog loaded with TIMEOUT -> WAIT.
//   WAIT:   eng_done: frames_done+1; if new count==N_FRAMES -> FINISH else -> ISSUE.
//           watchdog decrements each cycle; reaching 0 with no eng_done -> TIMEOUT_ERR=1,
//           eng_clear pulse, -> IDLE (DONE stays 0). eng_done same cycle as expiry wins.
//   FINISH: DONE=1 -> IDLE (one cycle). calc_finalizado = DONE.
//  BUSY = (state != IDLE). START while BUSY ignored. eng_done outside WAIT ignored.
//  ABORT (any state): -> IDLE next cycle, eng_clear pulse, frames_done kept, DONE unchanged.
//   ABORT and START in the same write: ABORT wins.
//  Status-clear write coincident with FINISH: set wins (DONE=1).
//  N_FRAMES/TIMEOUT writes while BUSY are accepted but take effect next run (latched at START).
//  frames_done saturates at 2^FRAME_W-1; frame counter compare is FRAME_W-bit, no wrap.
//  Reset mid-run: all outputs return to reset values next cycle; no eng_clear issued.
//  Start-to-first-eng_start latency: 2 cycles after write accepted.
// TESTING
//  N_FRAMES=3, START, engine answers eng_done 5 cycles after each eng_start -> 3 eng_start
//   pulses, 1 eng_clear, calc_finalizado=1 one cycle after 3rd done, STATUS=0x0003_0001.
//  TIMEOUT=10, START, engine silent -> eng_clear pulse at cycle 12, STATUS b2=1, DONE=0, BUSY=0.
//  ABORT after 1 of 4 frames -> IDLE, eng_clear pulse, STATUS=0x0001_0000, later done ignored.
//  N_FRAMES=0, START -> no eng_start, DONE=1 next cycle; IRQ_EN=1 -> irq=1; write STATUS=1
//   -> DONE=0, irq=0.
//  START during BUSY and status-clear coincident with FINISH -> no extra frames, DONE=1.
//  Assert reset in WAIT -> all outputs 0, readdata 0, N_FRAMES reads 1.

Source files
------------

// File: rtl/procesador_calc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : procesador_calc_sequencer_if
//  Description : Avalon-MM slave bus bundle between the Nios CPU and the
//                calc sequencer register block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface procesador_calc_sequencer_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    // CPU side drives the strobes and write data
    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata
    );

    // Sequencer side decodes the strobes and returns registered read data
    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/procesador_calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : procesador_calc_sequencer
//  Description : Runs N_FRAMES frames on the signal-processing engine after a
//                CPU START, with a per-frame watchdog, ABORT, and a sticky
//                run-complete flag (calc_finalizado) plus maskable IRQ.
//                Registers: 0 CTRL, 1 STATUS, 2 N_FRAMES, 3 TIMEOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module procesador_calc_sequencer #(
    parameter int                   FRAME_W     = 16,
    parameter int                   TIMEOUT_W   = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_DEF = 24'hFFFFFF
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    procesador_calc_sequencer_if.slave   bus,
    output logic                         eng_start,
    output logic                         eng_clear,
    input  wire logic                    eng_done,
    output logic                         calc_finalizado,
    output logic                         irq
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                 state_q,       state_d;
    logic                   eng_start_q,   eng_start_d;
    logic                   eng_clear_q,   eng_clear_d;
    logic                   done_q,        done_d;
    logic                   terr_q,        terr_d;
    logic                   irq_en_q,      irq_en_d;
    logic [FRAME_W-1:0]     n_frames_q,    n_frames_d;
    logic [FRAME_W-1:0]     run_frames_q,  run_frames_d;
    logic [FRAME_W-1:0]     frames_done_q, frames_done_d;
    logic [TIMEOUT_W-1:0]   timeout_q,     timeout_d;
    logic [TIMEOUT_W-1:0]   run_timeout_q, run_timeout_d;
    logic [TIMEOUT_W-1:0]   wd_q,          wd_d;
    logic [31:0]            readdata_q,    readdata_d;

    logic                   w_ctrl_wr;
    logic                   w_start;
    logic                   w_abort;
    logic                   w_stat_clr;
    logic [FRAME_W-1:0]     w_frames_inc;
    logic                   w_unused_bits;

    // Write decode; ABORT is checked ahead of START so it wins a combined write
    assign w_ctrl_wr  = bus.write && (bus.address == 2'd0);
    assign w_start    = w_ctrl_wr && bus.writedata[0];
    assign w_abort    = w_ctrl_wr && bus.writedata[1];
    assign w_stat_clr = bus.write && (bus.address == 2'd1) && bus.writedata[0];

    // Saturating frame counter increment
    assign w_frames_inc = (frames_done_q == {FRAME_W{1'b1}}) ? frames_done_q
                                                             : frames_done_q + FRAME_W'(1);

    // Reads have no side effects and upper write bits are don't-care
    assign w_unused_bits = ^{bus.read, bus.writedata[31:24]};

    assign eng_start       = eng_start_q;
    assign eng_clear       = eng_clear_q;
    assign calc_finalizado = done_q;
    assign irq             = done_q & irq_en_q;
    assign bus.readdata    = readdata_q;

    // State and register file update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            eng_start_q   <= 1'b0;
            eng_clear_q   <= 1'b0;
            done_q        <= 1'b0;
            terr_q        <= 1'b0;
            irq_en_q      <= 1'b0;
            n_frames_q    <= FRAME_W'(1);
            run_frames_q  <= FRAME_W'(1);
            frames_done_q <= '0;
            timeout_q     <= TIMEOUT_DEF;
            run_timeout_q <= TIMEOUT_DEF;
            wd_q          <= '0;
            readdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            eng_start_q   <= eng_start_d;
            eng_clear_q   <= eng_clear_d;
            done_q        <= done_d;
            terr_q        <= terr_d;
            irq_en_q      <= irq_en_d;
            n_frames_q    <= n_frames_d;
            run_frames_q  <= run_frames_d;
            frames_done_q <= frames_done_d;
            timeout_q     <= timeout_d;
            run_timeout_q <= run_timeout_d;
            wd_q          <= wd_d;
            readdata_q    <= readdata_d;
        end
    end

    // Next-state, register writes, engine pulses and read mux
    always_comb begin
        state_d       = state_q;
        eng_start_d   = 1'b0;
        eng_clear_d   = 1'b0;
        done_d        = done_q;
        terr_d        = terr_q;
        irq_en_d      = irq_en_q;
        n_frames_d    = n_frames_q;
        run_frames_d  = run_frames_q;
        frames_done_d = frames_done_q;
        timeout_d     = timeout_q;
        run_timeout_d = run_timeout_q;
        wd_d          = wd_q;
        readdata_d    = '0;

        // Configuration writes are always accepted; runs use latched copies
        if (w_ctrl_wr) begin
            irq_en_d = bus.writedata[2];
        end
        if (bus.write && (bus.address == 2'd2)) begin
            n_frames_d = bus.writedata[FRAME_W-1:0];
        end
        if (bus.write && (bus.address == 2'd3)) begin
            timeout_d = bus.writedata[TIMEOUT_W-1:0];
        end

        // Status clear first, so any set below in the same cycle wins
        if (w_stat_clr) begin
            done_d = 1'b0;
            terr_d = 1'b0;
        end

        if (w_abort) begin
            state_d     = S_IDLE;
            eng_clear_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_start) begin
                        if (n_frames_q != '0) begin
                            state_d       = S_CLEAR;
                            done_d        = 1'b0;
                            terr_d        = 1'b0;
                            frames_done_d = '0;
                            run_frames_d  = n_frames_q;
                            run_timeout_d = timeout_q;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    state_d = S_ISSUE;
                end
                S_ISSUE: begin
                    state_d = S_WAIT;
                    wd_d    = run_timeout_q;
                end
                S_WAIT: begin
                    // A done arriving on the expiry cycle still counts
                    if (eng_done) begin
                        frames_done_d = w_frames_inc;
                        if (w_frames_inc == run_frames_q) begin
                            state_d = S_FINISH;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end else if (wd_q <= TIMEOUT_W'(1)) begin
                        state_d     = S_IDLE;
                        terr_d      = 1'b1;
                        eng_clear_d = 1'b1;
                    end else begin
                        wd_d = wd_q - TIMEOUT_W'(1);
                    end
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Engine pulses are registered copies of the state being entered
        if (state_d == S_CLEAR) begin
            eng_clear_d = 1'b1;
        end
        eng_start_d = (state_d == S_ISSUE);

        case (bus.address)
            2'd0:    readdata_d = {29'd0, irq_en_q, 2'b00};
            2'd1:    readdata_d = {16'(frames_done_q), 13'd0, terr_q,
                                   (state_q != S_IDLE), done_q};
            2'd2:    readdata_d = 32'(n_frames_q);
            default: readdata_d = 32'(timeout_q);
        endcase
    end

endmodule
`default_nettype wire
